fetch_prefetch_unit: RTL

- Instruction fetch stage, directly upstream of the decoder.
- Issues in-order word requests to instruction memory and buffers returned words in a small prefetch FIFO.
- Presents {inst, inst_pc, inst_taken, inst_vld} to decode, with optional static branch prediction.
- Honours decode freeze (stall) and ALU branch-mispredict flush/redirect.

---
 rtl/fetch_prefetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: in-order imem requests, prefetch FIFO, decode handshake, flush/redirect.
// Define FETCH_STATIC_BPRED_EN to enable static prediction (JAL and backward branches taken).
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUT    = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvld,
  input  logic [31:0] imem_rdata,
  input  logic        dec_stall,
  input  logic        alu_flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_taken,
  output logic        inst_vld
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [0:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] mem_data [FIFO_DEPTH];
  logic [31:0] mem_pc   [FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, pop, accept, can_issue, pred_taken, pred_redirect;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  // A response is only kept when it is not a leftover from a discarded request stream.
  assign push       = imem_rvld & (drop_q == '0) & ~alu_flush;

`ifdef FETCH_STATIC_BPRED_EN
  logic [6:0]  opc;
  logic [31:0] j_imm, b_imm, pred_target;
  logic        mem_tkn [FIFO_DEPTH];

  assign opc         = imem_rdata[6:0];
  assign j_imm       = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign b_imm       = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign pred_taken  = (opc == 7'b1101111) | ((opc == 7'b1100011) & imem_rdata[31]);
  assign pred_target = resp_pc_q + ((opc == 7'b1101111) ? j_imm : b_imm);
  assign inst_taken  = fifo_empty ? 1'b0 : mem_tkn[rptr_q];

  always_ff @(posedge CLK) begin
    if (push) mem_tkn[wptr_q] <= pred_taken;
  end
`else
  assign pred_taken = 1'b0;
  assign inst_taken = 1'b0;
`endif

  assign pred_redirect = push & pred_taken;

  assign can_issue = (state_q == ST_RUN)
                   && ((32'(cnt_q) + 32'(out_q)) < 32'(FIFO_DEPTH))
                   && (32'(out_q) < 32'(MAX_OUT));
  assign imem_req  = can_issue & ~alu_flush & ~pred_redirect;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req & imem_gnt;

  assign inst_vld = ~fifo_empty & ~alu_flush;
  assign pop      = inst_vld & ~dec_stall;
  assign inst     = fifo_empty ? NOP   : mem_data[rptr_q];
  assign inst_pc  = fifo_empty ? '0    : mem_pc[rptr_q];

  assign out_d = out_q + OW'(accept) - OW'(imem_rvld);

  always_comb begin
    state_d    = ST_RUN;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    if (alu_flush) begin
      // Everything still in flight after this cycle belongs to the wrong path.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = out_d;
      wptr_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rvld && (drop_q != '0)) drop_d = drop_q - OW'(1);
      if (push) begin
        wptr_d    = wptr_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
`ifdef FETCH_STATIC_BPRED_EN
      if (pred_redirect) begin
        fetch_pc_d = pred_target;
        resp_pc_d  = pred_target;
        drop_d     = out_d;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wptr_q] <= imem_rdata;
      mem_pc[wptr_q]   <= resp_pc_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      assert (!(push && fifo_full && !pop));
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
